// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, 1 start / DBIT data (LSB first) / optional parity / stop.
// Latency: result pulses and rx_dout update one clk after the final stop-bit sample; rx path adds 2 clk sync.
// Backpressure: none; rx_done_tick is a 1-clk strobe that the consumer must catch.
// Optional feature: define UART_RX_PARITY_EN to add a parity bit (UART_RX_PARITY_ODD selects odd parity).
// Ports: clk, reset_n (async active-low), rx (serial in, idle high), s_tick (oversample strobe),
//        rx_dout (last good word), rx_done_tick / frame_err / parity_err (mutually exclusive pulses).
module uart_rx_core #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(DBIT + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_STOP = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

`ifdef UART_RX_PARITY_EN
`ifdef UART_RX_PARITY_ODD
  localparam logic PAR_ODD = 1'b1;
`else
  localparam logic PAR_ODD = 1'b0;
`endif
`endif

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_d;
  logic            done_d, ferr_d;

  // rx_sync[1] is the synchronised line; rx_sync[2] is its previous value for edge detection.
  // Resetting to 1 means an idle-high line never looks like a start edge after reset.
  logic [2:0] rx_sync;
  logic       rx_s, rx_prev;

  assign rx_s    = rx_sync[1];
  assign rx_prev = rx_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rx_sync <= 3'b111;
    else          rx_sync <= {rx_sync[1:0], rx};
  end

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_d;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    dout_d  = rx_dout;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        // Only a 1->0 transition starts a frame, so a held-low (break) line cannot retrigger.
        if (rx_prev && !rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_q == T_MID) begin
            if (!rx_s) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;  // line went back high by mid start bit: glitch
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_q == T_BIT) begin
            shreg_d = {rx_s, shreg_q[DBIT-1:1]};
            tick_d  = '0;
            bit_d   = bit_q + 1'b1;
            if (bit_q == B_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_q == T_BIT) begin
            // Data XOR parity bit is 0 for a good even frame and 1 for a good odd frame.
            par_bad_d = (^shreg_q) ^ rx_s ^ PAR_ODD;
            tick_d    = '0;
            state_d   = STOP;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_q == T_STOP) begin
            state_d = IDLE;
            // Framing error takes priority so at most one result pulse fires per frame.
            if (!rx_s) begin
              ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_q) begin
              perr_d = 1'b1;
`endif
            end else begin
              dout_d = shreg_q;
              done_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      rx_dout      <= dout_d;
      rx_done_tick <= done_d;
      frame_err    <= ferr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      par_bad_q  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bad_q  <= par_bad_d;
      parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed and randomized frames checked against a frame-level reference model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_uart_rx_core;

  localparam int OS       = 16;
  // Short divider keeps the run brief; the receiver only ever sees the tick rate, not the baud.
  localparam int BGEN_FV  = 9;
  localparam int BIT_CLKS = OS * (BGEN_FV + 1);

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`ifdef UART_RX_PARITY_ODD
  localparam bit PAR_ODD = 1'b1;
`else
  localparam bit PAR_ODD = 1'b0;
`endif
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx;
  logic       s_tick = 1'b0;
  logic [7:0] rx_dout;
  logic       rx_done_tick, frame_err, parity_err;

  uart_rx_core #(.DBIT(8), .OVERSAMPLE(OS), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .s_tick       (s_tick),
    .rx_dout      (rx_dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err),
    .parity_err   (parity_err)
  );

  always #5 clk = ~clk;

  // Free-running baud tick generator.
  int tick_cnt = 0;
  always @(posedge clk) begin
    if (tick_cnt == BGEN_FV) begin
      tick_cnt <= 0;
      s_tick   <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      s_tick   <= 1'b0;
    end
  end

  // Output monitor.
  int         done_cnt = 0, ferr_cnt = 0, perr_cnt = 0, excl_bad = 0, wide_bad = 0;
  logic [7:0] got_q[$];
  logic       prev_d = 1'b0, prev_f = 1'b0, prev_p = 1'b0;
  always @(negedge clk) begin
    if (rx_done_tick === 1'b1) begin
      done_cnt++;
      got_q.push_back(rx_dout);
    end
    if (frame_err === 1'b1)  ferr_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (int'(rx_done_tick) + int'(frame_err) + int'(parity_err) > 1) excl_bad++;
    if ((rx_done_tick && prev_d) || (frame_err && prev_f) || (parity_err && prev_p)) wide_bad++;
    prev_d = rx_done_tick;
    prev_f = frame_err;
    prev_p = parity_err;
  end

  // Reference model: expected outcome totals and last good word.
  int         exp_done = 0, exp_ferr = 0, exp_perr = 0;
  logic [7:0] exp_dout = 8'h00;
  logic [7:0] exp_q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic idle_clks(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ PAR_ODD ^ pflip);
`endif
    drive_bit(stop);
    if (!stop) begin
      exp_ferr++;
    end else if (PAR_EN && pflip) begin
      exp_perr++;
    end else begin
      exp_done++;
      exp_dout = d;
      exp_q.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_done"}, 32'(done_cnt), 32'(exp_done));
    chk({tag, "_ferr"}, 32'(ferr_cnt), 32'(exp_ferr));
    chk({tag, "_perr"}, 32'(perr_cnt), 32'(exp_perr));
    chk({tag, "_dout"}, 32'(rx_dout), 32'(exp_dout));
  endtask

  initial begin
    logic [7:0] d;
    logic       stop, pflip;
    int         gap;

    rx      = 1'b1;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_dout", 32'(rx_dout), 32'h0);
    chk("reset_done", 32'(rx_done_tick), 32'h0);
    chk("reset_ferr", 32'(frame_err), 32'h0);
    chk("reset_perr", 32'(parity_err), 32'h0);
    reset_n = 1'b1;
    idle_clks(2 * BIT_CLKS);

    // Single good frame.
    send_frame(8'h55, 1'b1, 1'b0);
    idle_clks(BIT_CLKS);
    check_all("f55");

    // Back-to-back frames, no idle gap between stop and next start.
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle_clks(BIT_CLKS);
    check_all("b2b");
    chk("b2b_first", 32'(got_q[got_q.size() >= 2 ? got_q.size() - 2 : 0]), 32'h0A3);
    chk("b2b_second", 32'(got_q[got_q.size() >= 1 ? got_q.size() - 1 : 0]), 32'h00F);

    // Stop bit low: framing error, word not updated.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle_clks(2 * BIT_CLKS);
    check_all("ferr3c");

    // Start glitch lasting 4 ticks only.
    rx = 1'b0;
    repeat (4 * (BGEN_FV + 1)) @(negedge clk);
    idle_clks(2 * BIT_CLKS);
    check_all("glitch");
    send_frame(8'h81, 1'b1, 1'b0);
    idle_clks(BIT_CLKS);
    check_all("f81");

    // Reset in the middle of the data bits of 0xFF.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    #2 reset_n = 1'b0;
    #1;
    exp_dout = 8'h00;
    chk("rstmid_dout", 32'(rx_dout), 32'h0);
    chk("rstmid_done", 32'(rx_done_tick), 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    idle_clks(2 * BIT_CLKS);
    check_all("rstmid_quiet");
    send_frame(8'h12, 1'b1, 1'b0);
    idle_clks(BIT_CLKS);
    check_all("f12");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    idle_clks(BIT_CLKS);
    check_all("par_good");
    send_frame(8'h07, 1'b1, 1'b1);
    idle_clks(BIT_CLKS);
    check_all("par_bad");
`endif

    // Randomized frames with random gaps; a bad stop bit always gets an idle gap afterwards.
    for (int i = 0; i < 10; i++) begin
      d     = 8'($urandom_range(0, 255));
      stop  = ($urandom_range(0, 3) != 0);
      pflip = PAR_EN && ($urandom_range(0, 3) == 0);
      send_frame(d, stop, pflip);
      gap = stop ? int'($urandom_range(0, BIT_CLKS)) : BIT_CLKS + int'($urandom_range(0, BIT_CLKS));
      idle_clks(gap);
      repeat (BIT_CLKS / 2 + 4) @(negedge clk);
      check_all($sformatf("rnd%0d", i));
    end

    idle_clks(BIT_CLKS);
    chk("words_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("word%0d", i), 32'(i < got_q.size() ? got_q[i] : 8'hxx), 32'(exp_q[i]));
    end
    chk("pulse_exclusive", 32'(excl_bad), 32'h0);
    chk("pulse_width", 32'(wide_bad), 32'h0);
    if (!PAR_EN) chk("perr_never", 32'(perr_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
